// File: rtl/cop0_irq_ctrl.sv
// CP0 interrupt requester: synchronizes lines, latches rising edges as pending, masks and picks the
// highest eligible line, and holds one request to CP0 until acked. Macro COP0_IRQ_LEVEL_EN selects level mode.
module cop0_irq_ctrl #(
  parameter int NLINES = 6,
  parameter int NUMW   = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NLINES-1:0] irq_i,
  input  logic [NLINES-1:0] mask_i,
  input  logic              ie_i,
  output logic              irq_req_o,
  output logic [NUMW-1:0]   irq_num_o,
  input  logic              irq_ack_i,
  input  logic              clr_we_i,
  input  logic [NLINES-1:0] clr_mask_i,
  output logic [NLINES-1:0] pend_o
);

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t            state_q;
  logic [NLINES-1:0] s1_q, s2_q;
  logic [NLINES-1:0] pend_q, pend_d;
  logic [NLINES-1:0] elig;
  logic [NUMW-1:0]   win;
  logic              req_q;
  logic [NUMW-1:0]   num_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= irq_i;
      s2_q <= s1_q;
    end
  end

`ifdef COP0_IRQ_LEVEL_EN
  // Pending mirrors the synchronized level one cycle later, keeping the 3-cycle request latency.
  logic unused_clr;
  assign unused_clr = clr_we_i | (|clr_mask_i);

  always_comb begin
    pend_d = s2_q;
  end
`else
  logic [NLINES-1:0] s3_q;
  logic [NLINES-1:0] rise;
  logic [NLINES-1:0] clr;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) s3_q <= '0;
    else       s3_q <= s2_q;
  end

  assign rise = s2_q & ~s3_q;

  always_comb begin
    clr = clr_we_i ? clr_mask_i : '0;
    for (int i = 0; i < NLINES; i++) begin
      if (irq_ack_i && req_q && (num_q == NUMW'(i))) clr[i] = 1'b1;
    end
    // A rise in the same cycle as its clear wins, so no edge is dropped.
    pend_d = (pend_q & ~clr) | rise;
  end
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign elig = ie_i ? (pend_q & mask_i) : '0;

  always_comb begin
    win = '0;
    for (int i = 0; i < NLINES; i++) begin
      if (elig[i]) win = NUMW'(i);
    end
  end

  // The request is frozen in REQ; only an ack releases it, regardless of mask/IE/pending changes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      num_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|elig) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            num_q   <= win;
          end
        end
        ST_REQ: begin
          if (irq_ack_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            num_q   <= '0;
          end
        end
      endcase
    end
  end

  assign irq_req_o = req_q;
  assign irq_num_o = num_q;
  assign pend_o    = pend_q;

endmodule

// File: tb/tb_cop0_irq_ctrl.sv
// Directed + random bench for cop0_irq_ctrl against a sampled-history reference model.
module tb_cop0_irq_ctrl;
  localparam int NL = 6;
  localparam int NW = 3;

  logic          clk = 1'b0;
  logic          nrst;
  logic [NL-1:0] irq_i, mask_i, clr_mask_i, pend_o;
  logic          ie_i, irq_ack_i, clr_we_i, irq_req_o;
  logic [NW-1:0] irq_num_o;

  int vectors = 0;
  int miscompares = 0;

  cop0_irq_ctrl #(.NLINES(NL), .NUMW(NW)) dut (
    .clk(clk), .nrst(nrst), .irq_i(irq_i), .mask_i(mask_i), .ie_i(ie_i),
    .irq_req_o(irq_req_o), .irq_num_o(irq_num_o), .irq_ack_i(irq_ack_i),
    .clr_we_i(clr_we_i), .clr_mask_i(clr_mask_i), .pend_o(pend_o)
  );

  always #5 clk = ~clk;

  // Reference model: history of irq_i as sampled at each clock edge, plus pending set and request.
  logic [NL-1:0] samp_q[$];
  logic [NL-1:0] m_pend;
  logic          m_req;
  logic [NW-1:0] m_num;

  task automatic model_reset();
    samp_q.delete();
    repeat (3) samp_q.push_back('0);
    m_pend = '0;
    m_req  = 1'b0;
    m_num  = '0;
  endtask

  task automatic model_edge();
    logic [NL-1:0] elig, clr, nxt;
    int n;
    n    = samp_q.size();
    elig = ie_i ? (m_pend & mask_i) : '0;
`ifdef COP0_IRQ_LEVEL_EN
    nxt = samp_q[n-2];
`else
    clr = clr_we_i ? clr_mask_i : '0;
    if (m_req && irq_ack_i) clr = clr | (NL'(1) << m_num);
    nxt = (m_pend & ~clr) | (samp_q[n-2] & ~samp_q[n-3]);
`endif
    if (m_req) begin
      if (irq_ack_i) begin
        m_req = 1'b0;
        m_num = '0;
      end
    end else if (elig != '0) begin
      m_req = 1'b1;
      for (int i = NL-1; i >= 0; i--) begin
        if (elig[i]) begin
          m_num = NW'(i);
          break;
        end
      end
    end
    m_pend = nxt;
    samp_q.push_back(irq_i);
    if (samp_q.size() > 4) void'(samp_q.pop_front());
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (nrst) model_edge();
    #1;
    check({tag, ".req"}, 32'(irq_req_o), 32'(m_req));
    check({tag, ".pend"}, 32'(pend_o), 32'(m_pend));
    if (m_req) check({tag, ".num"}, 32'(irq_num_o), 32'(m_num));
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    int hold;
    nrst = 1'b0; irq_i = '0; mask_i = '0; ie_i = 1'b0;
    irq_ack_i = 1'b0; clr_we_i = 1'b0; clr_mask_i = '0;
    model_reset();
    steps("rst", 2);
    check("rst.req0", 32'(irq_req_o), 32'd0);
    check("rst.num0", 32'(irq_num_o), 32'd0);
    check("rst.pend0", 32'(pend_o), 32'd0);
    nrst = 1'b1;

    // Single edge on line 2
    mask_i = 6'h3F; ie_i = 1'b1; irq_i = 6'h04;
    steps("single", 3);
    check("single.pend", 32'(pend_o), 32'h04);
    step("single");
    check("single.req", 32'(irq_req_o), 32'd1);
    check("single.num", 32'(irq_num_o), 32'd2);
    irq_ack_i = 1'b1;
    step("single.ack");
    irq_ack_i = 1'b0;
    check("single.ackreq", 32'(irq_req_o), 32'd0);
`ifndef COP0_IRQ_LEVEL_EN
    check("single.ackpend", 32'(pend_o), 32'd0);
`endif
    irq_i = '0;
    steps("idle", 4);

    // Priority between lines 1 and 4
    irq_i = 6'h12;
    steps("prio", 4);
    check("prio.num4", 32'(irq_num_o), 32'd4);
    irq_ack_i = 1'b1;
    step("prio.ack");
    irq_ack_i = 1'b0;
    check("prio.gap", 32'(irq_req_o), 32'd0);
    step("prio");
`ifndef COP0_IRQ_LEVEL_EN
    check("prio.num1", 32'(irq_num_o), 32'd1);
`endif
    check("prio.req1", 32'(irq_req_o), 32'd1);
    irq_ack_i = 1'b1;
    step("prio.ack2");
    irq_ack_i = 1'b0;
    irq_i = '0;
    steps("idle", 4);

    // Masked line becomes eligible when its IM bit is set
    mask_i = 6'h01; irq_i = 6'h08;
    steps("mask", 3);
    check("mask.pend", 32'(pend_o), 32'h08);
    step("mask");
    check("mask.noreq", 32'(irq_req_o), 32'd0);
    mask_i = 6'h09;
    step("mask");
    check("mask.req", 32'(irq_req_o), 32'd1);
    check("mask.num", 32'(irq_num_o), 32'd3);
    irq_ack_i = 1'b1;
    step("mask.ack");
    irq_ack_i = 1'b0;
    irq_i = '0; mask_i = 6'h3F;
    steps("idle", 4);

    // New rise on line 5 coincides with its ack; request must also hold while IE/mask drop
    irq_i = 6'h20;
    steps("coll", 4);
    check("coll.num", 32'(irq_num_o), 32'd5);
    irq_i = '0; ie_i = 1'b0; mask_i = '0;
    steps("coll.hold", 2);
    check("coll.held", 32'(irq_req_o), 32'd1);
    irq_i = 6'h20; ie_i = 1'b1; mask_i = 6'h3F;
    steps("coll", 2);
    irq_ack_i = 1'b1;
    step("coll.ack");
    irq_ack_i = 1'b0;
    check("coll.pend5", 32'(pend_o[5]), 32'd1);
    check("coll.gap", 32'(irq_req_o), 32'd0);
    step("coll");
    check("coll.req2", 32'(irq_req_o), 32'd1);
    irq_ack_i = 1'b1;
    step("coll.ack2");
    irq_ack_i = 1'b0;
    irq_i = '0;
    steps("idle", 4);

    // Software clear
    mask_i = '0; irq_i = 6'h30;
    steps("clr", 3);
    check("clr.pend30", 32'(pend_o), 32'h30);
    clr_we_i = 1'b1; clr_mask_i = 6'h10;
    step("clr");
    clr_we_i = 1'b0;
`ifdef COP0_IRQ_LEVEL_EN
    check("clr.pend", 32'(pend_o), 32'h30);
`else
    check("clr.pend", 32'(pend_o), 32'h20);
`endif
    irq_i = '0; clr_we_i = 1'b1; clr_mask_i = 6'h3F;
    step("clr");
    clr_we_i = 1'b0; clr_mask_i = '0;
    steps("idle", 4);

    // Reset in the middle of a request
    mask_i = 6'h3F; irq_i = 6'h01;
    steps("mreset", 4);
    check("mreset.req", 32'(irq_req_o), 32'd1);
    #2 nrst = 1'b0;
    #1;
    check("mreset.req0", 32'(irq_req_o), 32'd0);
    check("mreset.pend0", 32'(pend_o), 32'd0);
    model_reset();
    step("mreset.in");
    nrst = 1'b1;
    step("mreset.out");
    check("mreset.after", 32'(irq_req_o), 32'd0);
    irq_i = '0;
    steps("idle", 4);

    // Random traffic
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        irq_i = NL'($urandom);
        hold  = $urandom_range(2, 8);
      end else begin
        hold--;
      end
      irq_ack_i  = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      clr_we_i   = ($urandom_range(0, 7) == 0);
      clr_mask_i = NL'($urandom);
      if ($urandom_range(0, 15) == 0) mask_i = NL'($urandom);
      if ($urandom_range(0, 15) == 0) ie_i = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
